// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_pkg
//  Purpose  : Shared types and constants for the bit-serial ALU slots.
//             Holds the state enum used by the serial arithmetic FSMs and
//             the default operand width.
//  Revision : 1.0  initial release
// ============================================================================
package serial_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : serial_alu_pkg
`default_nettype wire

// File: rtl/fullsubtractor.sv
`default_nettype none
// ============================================================================
//  Module   : fullsubtractor
//  Purpose  : Single-bit combinational subtract cell, computes a - b - bin.
//             Port order mirrors the fulladder cell (outputs first).
//  Ports    : diff (out) difference bit
//             bout (out) borrow out
//             a    (in)  minuend bit
//             b    (in)  subtrahend bit
//             bin  (in)  borrow in
//  Revision : 1.0  initial release
// ============================================================================
module fullsubtractor (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    always_comb begin
        diff = a ^ b ^ bin;
        // Borrow when b exceeds a outright, or when they tie and a borrow
        // is already pending from the lower bit.
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : fullsubtractor
`default_nettype wire

// File: rtl/serial_subtraction.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtraction
//  Purpose  : Bit-serial WIDTH-bit subtractor, Z = X - Y, one bit per clock,
//             LSB first, with a start/done handshake.
//  Ports    : clk    (in)  rising-edge clock
//             rst_n  (in)  asynchronous active-low reset
//             start  (in)  request, sampled only while idle
//             X      (in)  minuend, captured on accepted start
//             Y      (in)  subtrahend, captured on accepted start
//             Z      (out) difference mod 2^WIDTH, registered
//             bout   (out) borrow out of the MSB (X < Y unsigned), registered
//             busy   (out) high while shifting and during the done cycle
//             done   (out) one-cycle completion pulse
//             ovf    (out) signed overflow, only when SUB_OVERFLOW_EN defined
//  Options  : `define SUB_OVERFLOW_EN adds the ovf port and its logic.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtraction
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic [WIDTH-1:0]   z_q,      z_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               borrow_q, borrow_d;
    logic               bout_q,   bout_d;

    logic               w_diff;
    logic               w_bout;

    fullsubtractor u_fs (
        .diff (w_diff),
        .bout (w_bout),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        z_d      = z_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = X;
                    b_d      = Y;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Difference bits enter at the MSB so that after WIDTH shifts
                // bit 0 of the result has reached position 0.
                res_d    = {w_diff, res_q[WIDTH-1:1]};
                borrow_d = w_bout;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    z_d     = {w_diff, res_q[WIDTH-1:1]};
                    bout_d  = w_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            z_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            z_q      <= z_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Operand MSBs are shifted out of the operand registers during SHIFT,
    // so they are kept separately from the moment of acceptance.
    logic xmsb_q, xmsb_d;
    logic ymsb_q, ymsb_d;
    logic ovf_q,  ovf_d;

    always_comb begin
        xmsb_d = xmsb_q;
        ymsb_d = ymsb_q;
        ovf_d  = ovf_q;
        if (state_q == IDLE && start) begin
            xmsb_d = X[WIDTH-1];
            ymsb_d = Y[WIDTH-1];
        end
        // The final diff bit is the result MSB.
        if (state_q == SHIFT && cnt_q == CNT_LAST) begin
            ovf_d = (xmsb_q != ymsb_q) && (w_diff != xmsb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmsb_q <= 1'b0;
            ymsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            xmsb_q <= xmsb_d;
            ymsb_q <= ymsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign Z    = z_q;
    assign bout = bout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule : serial_subtraction
`default_nettype wire

// File: tb/tb_serial_subtraction.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtraction
//  Purpose  : Self-checking bench for serial_subtraction (WIDTH=8). Expected
//             results come from plain integer arithmetic on the operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtraction;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    serial_subtraction #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: plain modular / signed integer arithmetic.
    function automatic logic [WIDTH-1:0] ref_z(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int d;
        d = int'(x) - int'(y);
        return WIDTH'(d);
    endfunction

    function automatic logic ref_bout(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int sx, sy, sd;
        sx = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
        sy = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
        sd = sx - sy;
        return (sd > 127) || (sd < -128);
    endfunction

    task automatic check_result(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        check_eq({tag, ".Z"},    32'(Z),    32'(ref_z(x, y)));
        check_eq({tag, ".bout"}, 32'(bout), 32'(ref_bout(x, y)));
`ifdef SUB_OVERFLOW_EN
        check_eq({tag, ".ovf"},  32'(ovf),  32'(ref_ovf(x, y)));
`endif
    endtask

    // One full operation: checks latency, busy length, result and the
    // return to idle one cycle after the done pulse.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int  n;
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        X = x; Y = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        X = WIDTH'($urandom);
        Y = WIDTH'($urandom);
        n = 0; busy_cycles = 0; seen = 0;
        for (int k = 0; k < 3 * WIDTH && !seen; k++) begin
            if (busy) busy_cycles++;
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!seen) begin
            check_eq({tag, ".timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, ".latency"},   32'(n),           32'(WIDTH));
            check_eq({tag, ".busy_len"},  32'(busy_cycles), 32'(WIDTH + 1));
            check_result(tag, x, y);
            @(posedge clk); #1;
            check_eq({tag, ".done_off"},  32'(done), 32'd0);
            check_eq({tag, ".idle"},      32'(busy), 32'd0);
        end
    endtask

    logic [WIDTH-1:0] ex, ey;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        X = '0;
        Y = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.Z",    32'(Z),    32'd0);
        check_eq("rst.bout", 32'(bout), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
`ifdef SUB_OVERFLOW_EN
        check_eq("rst.ovf",  32'(ovf),  32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // start while idle but deasserted must not launch anything
        repeat (2) @(posedge clk);
        #1;
        check_eq("nostart.busy", 32'(busy), 32'd0);

        run_op("basic",   8'd100, 8'd37);
        run_op("neg",     8'd5,   8'd10);
        run_op("ovf_a",   8'h80,  8'h01);
        run_op("ovf_b",   8'h7F,  8'hFF);
        run_op("zero",    8'h00,  8'h00);
        run_op("yzero",   8'hFF,  8'h00);

        // start held high: an operation every WIDTH+2 cycles; inputs that
        // change between acceptances must not affect the result in progress.
        for (int c = 0; c < 3 * (WIDTH + 2); c++) begin
            @(negedge clk);
            start = 1'b1;
            if (c % (WIDTH + 2) == 0) begin
                ex = (c == 0) ? 8'd3 : WIDTH'($urandom);
                ey = (c == 0) ? 8'd3 : WIDTH'($urandom);
                X = ex; Y = ey;
            end else begin
                X = WIDTH'($urandom);
                Y = WIDTH'($urandom);
            end
            @(posedge clk); #1;
            check_eq("hold.done", 32'(done), 32'(c % (WIDTH + 2) == WIDTH));
            if (c % (WIDTH + 2) == WIDTH) check_result("hold", ex, ey);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);

        // reset four cycles into an operation aborts it at once
        @(negedge clk);
        X = 8'd200; Y = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort.Z",    32'(Z),    32'd0);
        check_eq("abort.bout", 32'(bout), 32'd0);
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 8'd9, 8'd4);

        // randomized operations
        for (int i = 0; i < 20; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_serial_subtraction
`default_nettype wire
